// File: rtl/reg_skid_stage_pkg.sv
// Shared definitions for the elastic skid stage: occupancy encodings and defaults.
package reg_skid_stage_pkg;

    localparam int DP_DATAWIDTH_DEFAULT = 64;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Storage slot indices; slot 0 drives out_data, slot 1 catches a word during a stall.
    localparam int IDX_MAIN = 0;
    localparam int IDX_SKID = 1;

endpackage

// File: rtl/reg_skid_stage_reg_en.sv
// Plain datapath register with load enable; clears to zero on reset.
module reg_en #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 en,
    input  logic [DATAWIDTH-1:0] d,
    output logic [DATAWIDTH-1:0] q
);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_skid_stage.sv
// Valid/ready pipeline stage with a two-word skid buffer; in_ready depends only on
// registered state so out_ready never reaches it combinationally.
module reg_skid_stage
    import reg_skid_stage_pkg::*;
#(
    parameter int DATAWIDTH = DP_DATAWIDTH_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           level
);

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic                 reg_load [2];
    logic [DATAWIDTH-1:0] reg_d    [2];
    logic [DATAWIDTH-1:0] reg_q    [2];
    logic                 acc_in;
    logic                 acc_out;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_store
            reg_en #(.DATAWIDTH(DATAWIDTH)) u_reg (
                .Clk (Clk),
                .Rst (Rst),
                .en  (reg_load[gi]),
                .d   (reg_d[gi]),
                .q   (reg_q[gi])
            );
        end
    endgenerate

    // The illegal encoding 3 decodes as not valid and empties on the next edge.
    assign out_valid = (state_reg == ST_BUSY) || (state_reg == ST_FULL);
    assign in_ready  = (state_reg != ST_FULL) && Rst;
    assign level     = out_valid ? state_reg : ST_EMPTY;
    assign out_data  = reg_q[IDX_MAIN];

    assign acc_in  = in_valid & in_ready;
    assign acc_out = out_valid & out_ready;

    // Main refills from the skid slot when draining FULL, otherwise from upstream.
    assign reg_d[IDX_MAIN] = (state_reg == ST_FULL) ? reg_q[IDX_SKID] : in_data;
    assign reg_d[IDX_SKID] = in_data;

    always_comb begin
        state_next         = state_reg;
        reg_load[IDX_MAIN] = 1'b0;
        reg_load[IDX_SKID] = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (acc_in) begin
                    reg_load[IDX_MAIN] = 1'b1;
                    state_next         = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (acc_in && acc_out) begin
                    reg_load[IDX_MAIN] = 1'b1;
                end else if (acc_in) begin
                    reg_load[IDX_SKID] = 1'b1;
                    state_next         = ST_FULL;
                end else if (acc_out) begin
                    state_next         = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (acc_out) begin
                    reg_load[IDX_MAIN] = 1'b1;
                    state_next         = ST_BUSY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

endmodule

// File: tb/tb_reg_skid_stage.sv
// Directed and random checks of reg_skid_stage at 64-bit and 8-bit widths in lockstep.
module tb_reg_skid_stage;

    logic        Clk;
    logic        Rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready,  in_ready8;
    logic [63:0] out_data;
    logic [7:0]  out_data8;
    logic        out_valid, out_valid8;
    logic [1:0]  level,     level8;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb_q[$];

    reg_skid_stage #(.DATAWIDTH(64)) dut64 (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    reg_skid_stage #(.DATAWIDTH(8)) dut8 (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_data   (in_data[7:0]),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .out_data  (out_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .level     (level8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [63:0] d,
                             input logic [1:0] lv, input logic rdy);
        check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
        if (v) check({tag, ".data"}, out_data, d);
        check({tag, ".level"}, {62'd0, level}, {62'd0, lv});
        check({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, rdy});
        if (v && out_ready) $display("xfer %s data=%h", tag, out_data);
    endtask

    initial begin
        Rst       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset held for three cycles, with stimulus that would otherwise be accepted.
        #1;
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_out("reset", 1'b0, 64'd0, 2'd0, 1'b0);
            check("reset.data0", out_data, 64'd0);
            cyc();
        end
        in_valid = 1'b0;
        Rst      = 1'b1;
        @(negedge Clk);
        check_out("release", 1'b0, 64'd0, 2'd0, 1'b1);
        cyc();

        // Full-rate streaming 1..8.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 64'(i);
            @(negedge Clk);
            if (i == 1) check_out("stream0", 1'b0, 64'd0, 2'd0, 1'b1);
            else        check_out("stream", 1'b1, 64'(i - 1), 2'd1, 1'b1);
            cyc();
        end
        in_valid = 1'b0;
        @(negedge Clk);
        check_out("stream_last", 1'b1, 64'd8, 2'd1, 1'b1);
        cyc();
        @(negedge Clk);
        check_out("stream_drain", 1'b0, 64'd0, 2'd0, 1'b1);
        cyc();

        // Backpressure fill, then a held upstream word while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA5;
        cyc();
        in_data   = 64'h5A;
        cyc();
        in_data   = 64'h33;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check_out("stall", 1'b1, 64'hA5, 2'd2, 1'b0);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge Clk);
        check_out("drain_a5", 1'b1, 64'hA5, 2'd2, 1'b0);
        cyc();
        @(negedge Clk);
        check_out("drain_5a", 1'b1, 64'h5A, 2'd1, 1'b1);
        cyc();
        in_valid = 1'b0;
        @(negedge Clk);
        check_out("drain_33", 1'b1, 64'h33, 2'd1, 1'b1);
        cyc();
        @(negedge Clk);
        check_out("drain_done", 1'b0, 64'd0, 2'd0, 1'b1);
        cyc();

        // Asynchronous reset pulse while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA5;
        cyc();
        in_data   = 64'h5A;
        cyc();
        in_valid  = 1'b0;
        @(negedge Clk);
        check_out("pre_rst", 1'b1, 64'hA5, 2'd2, 1'b0);
        Rst = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 64'd0, 2'd0, 1'b0);
        check("async_rst.data0", out_data, 64'd0);
        #1;
        Rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check_out("post_rst", 1'b0, 64'd0, 2'd0, 1'b1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_out("no_stale", 1'b0, 64'd0, 2'd0, 1'b1);
            cyc();
        end
        in_valid = 1'b1;
        in_data  = 64'h77;
        cyc();
        in_valid = 1'b0;
        @(negedge Clk);
        check_out("after_rst", 1'b1, 64'h77, 2'd1, 1'b1);
        cyc();
        @(negedge Clk);
        check_out("after_rst_empty", 1'b0, 64'd0, 2'd0, 1'b1);
        cyc();

        // Random handshakes against a FIFO scoreboard; both widths share control.
        sb_q.delete();
        for (int c = 0; c < 2000; c++) begin
            logic        m_rdy, m_vld, r0, r8;
            logic [63:0] head;
            if (!(in_valid && sb_q.size() == 2)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge Clk);
            m_rdy = (sb_q.size() < 2);
            m_vld = (sb_q.size() > 0);
            head  = m_vld ? sb_q[0] : 64'd0;
            check("rnd.in_ready",  {63'd0, in_ready},   {63'd0, m_rdy});
            check("rnd.in_ready8", {63'd0, in_ready8},  {63'd0, m_rdy});
            check("rnd.valid",     {63'd0, out_valid},  {63'd0, m_vld});
            check("rnd.valid8",    {63'd0, out_valid8}, {63'd0, m_vld});
            check("rnd.level",     {62'd0, level},  64'(sb_q.size()));
            check("rnd.level8",    {62'd0, level8}, 64'(sb_q.size()));
            if (m_vld) begin
                check("rnd.data",  out_data, head);
                check("rnd.data8", {56'd0, out_data8}, {56'd0, head[7:0]});
            end
            r0 = in_ready;
            r8 = in_ready8;
            out_ready = ~out_ready;
            #1;
            check("rnd.comb",  {63'd0, in_ready},  {63'd0, r0});
            check("rnd.comb8", {63'd0, in_ready8}, {63'd0, r8});
            out_ready = ~out_ready;
            #1;
            if (m_vld && out_ready) begin
                $display("xfer rnd cycle=%0d data=%h", c, head);
                void'(sb_q.pop_front());
            end
            if (in_valid && m_rdy) sb_q.push_back(in_data);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
